fifo_v4: RTL and testbench

FIFO_V4 -- requirements
Module: fifo_v4

---
 rtl/fifo_v4.sv | 183 ++++++++++++++++++
 tb/tb_fifo_v4.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_v4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fifo_v4                                                    |
// | Description : Synchronous single-clock FIFO with valid/ready handshakes, |
// |               optional fall-through, occupancy and almost-full/empty     |
// |               status. Depth need not be a power of two.                  |
// | Options     : define GROVF_RDMA_FIFO_PEAK_EN to build the occupancy      |
// |               high-water-mark tracker driving peak_o; otherwise peak_o   |
// |               is tied to zero.                                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fifo_v4 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ALM_FULL_TH  = DEPTH - 1,
  parameter int unsigned ALM_EMPTY_TH = 1,
  localparam int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  // push side
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  // pop side
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  // status
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [CNT_W-1:0]      usage_o,
  output logic [CNT_W-1:0]      peak_o
);

  // A single-entry FIFO still needs a one-bit pointer to keep the array
  // indexing well formed.
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0]  C_DEPTH    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  C_AF_TH    = CNT_W'(ALM_FULL_TH);
  localparam logic [CNT_W-1:0]  C_AE_TH    = CNT_W'(ALM_EMPTY_TH);
  localparam logic [ADDR_W-1:0] C_LAST_PTR = ADDR_W'(DEPTH - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      usage_q,  usage_d;

  logic w_is_empty;
  logic w_ft_active;
  logic w_push;
  logic w_pop;
  logic w_wr_en;

  // The clock-gate bypass has no functional role in this flop-based array.
  logic unused_testmode;
  assign unused_testmode = testmode_i;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    if (p == C_LAST_PTR) begin
      return '0;
    end
    return p + ADDR_W'(1);
  endfunction

  // --------------------------------------------------------------------------
  // Handshake and status decode
  // --------------------------------------------------------------------------
  assign w_is_empty = (usage_q == '0);

  // Fall-through is live only while storage is empty and a writer is
  // presenting data; the input is then routed straight to the output.
  assign w_ft_active = FALL_THROUGH & w_is_empty & valid_i;

  assign full_o         = (usage_q == C_DEPTH);
  assign ready_o        = ~full_o;
  assign empty_o        = w_is_empty & ~w_ft_active;
  assign valid_o        = ~empty_o;
  assign almost_full_o  = (usage_q >= C_AF_TH);
  assign almost_empty_o = (usage_q <= C_AE_TH);
  assign usage_o        = usage_q;

  assign data_o = w_ft_active ? data_i : mem_q[rd_ptr_q];

  // A fall-through item consumed in the same cycle never touches storage.
  // ready_o depends only on the registered count, so a pop at full cannot
  // open the push side in the same cycle.
  assign w_push = valid_i & ready_o & ~(w_ft_active & ready_i);
  assign w_pop  = valid_o & ready_i & ~w_ft_active;

  // A flush discards any push presented alongside it.
  assign w_wr_en = w_push & ~flush_i;

  // Next-state for pointers and occupancy; flush overrides everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usage_d  = usage_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usage_d  = '0;
    end else begin
      if (w_push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (w_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({w_push, w_pop})
        2'b10:   usage_d = usage_q + CNT_W'(1);
        2'b01:   usage_d = usage_q - CNT_W'(1);
        default: usage_d = usage_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usage_q  <= usage_d;
    end
  end

  // Storage array: cleared on reset, written only by an accepted push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (w_wr_en) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // --------------------------------------------------------------------------
  // Occupancy high-water mark
  // --------------------------------------------------------------------------
`ifdef GROVF_RDMA_FIFO_PEAK_EN
  logic [CNT_W-1:0] peak_q, peak_d;

  // Track the largest occupancy seen since the last reset or flush.
  always_comb begin
    peak_d = peak_q;
    if (flush_i) begin
      peak_d = '0;
    end else if (usage_d > peak_q) begin
      peak_d = usage_d;
    end
  end

  // Peak register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_o = peak_q;
`else
  assign peak_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_v4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fifo_v4                                                 |
// | Description : Directed self-checking bench for fifo_v4. Instance A is a  |
// |               registered FIFO (DEPTH=5), instance B a fall-through one.  |
// |               Peak expectations follow GROVF_RDMA_FIFO_PEAK_EN.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fifo_v4;

  localparam int DW  = 8;
  localparam int DEP = 5;
  localparam int CW  = 3;
`ifdef GROVF_RDMA_FIFO_PEAK_EN
  localparam int PEAK_ON = 1;
`else
  localparam int PEAK_ON = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Instance A signals
  logic          a_flush, a_vin, a_rdy;
  logic [DW-1:0] a_din, a_dout;
  logic          a_vout, a_rout, a_full, a_empty, a_af, a_ae;
  logic [CW-1:0] a_usage, a_peak;

  // Instance B signals
  logic          b_flush, b_vin, b_rdy;
  logic [DW-1:0] b_din, b_dout;
  logic          b_vout, b_rout, b_full, b_empty, b_af, b_ae;
  logic [CW-1:0] b_usage, b_peak;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_v4 #(
    .FALL_THROUGH(1'b0), .DATA_WIDTH(DW), .DEPTH(DEP),
    .ALM_FULL_TH(4), .ALM_EMPTY_TH(1)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush), .testmode_i(1'b0),
    .data_i(a_din), .valid_i(a_vin), .ready_o(a_rout),
    .data_o(a_dout), .valid_o(a_vout), .ready_i(a_rdy),
    .full_o(a_full), .empty_o(a_empty),
    .almost_full_o(a_af), .almost_empty_o(a_ae),
    .usage_o(a_usage), .peak_o(a_peak)
  );

  fifo_v4 #(
    .FALL_THROUGH(1'b1), .DATA_WIDTH(DW), .DEPTH(DEP),
    .ALM_FULL_TH(4), .ALM_EMPTY_TH(1)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush), .testmode_i(1'b0),
    .data_i(b_din), .valid_i(b_vin), .ready_o(b_rout),
    .data_o(b_dout), .valid_o(b_vout), .ready_i(b_rdy),
    .full_o(b_full), .empty_o(b_empty),
    .almost_full_o(b_af), .almost_empty_o(b_ae),
    .usage_o(b_usage), .peak_o(b_peak)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_push(input logic [DW-1:0] d);
    a_vin = 1'b1;
    a_din = d;
    a_rdy = 1'b0;
    tick();
    a_vin = 1'b0;
  endtask

  task automatic a_pop(input string tag, input logic [DW-1:0] exp);
    a_rdy = 1'b1;
    @(negedge clk);
    check(tag, a_dout, exp);
    check({tag, "_valid"}, a_vout, 1);
    tick();
    a_rdy = 1'b0;
  endtask

  task automatic a_reset_state(input string tag);
    check({tag, "_data"},  a_dout,  0);
    check({tag, "_valid"}, a_vout,  0);
    check({tag, "_ready"}, a_rout,  1);
    check({tag, "_empty"}, a_empty, 1);
    check({tag, "_full"},  a_full,  0);
    check({tag, "_ae"},    a_ae,    1);
    check({tag, "_af"},    a_af,    0);
    check({tag, "_usage"}, a_usage, 0);
    check({tag, "_peak"},  a_peak,  0);
  endtask

  initial begin
    a_flush = 0; a_vin = 0; a_rdy = 0; a_din = '0;
    b_flush = 0; b_vin = 0; b_rdy = 0; b_din = '0;

    // ---------------- reset values, no clock edge needed ----------------
    #1 rst_n = 1'b0;
    #1;
    a_reset_state("rst");
    check("rst_b_valid", b_vout,  0);
    check("rst_b_empty", b_empty, 1);
    check("rst_b_data",  b_dout,  0);
    #20 rst_n = 1'b1;
    tick();

    // ---------------- fill 1..5, then drain in order ----------------
    for (int i = 1; i <= 5; i++) begin
      a_vin = 1'b1;
      a_din = DW'(i);
      @(negedge clk);
      check("fill_usage", a_usage, i - 1);
      check("fill_af",    a_af,    (i - 1) >= 4);
      check("fill_ae",    a_ae,    (i - 1) <= 1);
      check("fill_ready", a_rout,  1);
      tick();
    end
    a_vin = 1'b0;
    @(negedge clk);
    check("full_full",  a_full,  1);
    check("full_ready", a_rout,  0);
    check("full_usage", a_usage, 5);
    check("full_peak",  a_peak,  PEAK_ON ? 5 : 0);
    tick();
    for (int i = 1; i <= 5; i++) a_pop("drain_data", DW'(i));
    @(negedge clk);
    check("drain_empty", a_empty, 1);
    check("drain_usage", a_usage, 0);
    tick();

    // ---------------- pointer wrap with order preserved ----------------
    a_push(8'h11); a_push(8'h12); a_push(8'h13);
    a_pop("wrap_a", 8'h11); a_pop("wrap_a", 8'h12); a_pop("wrap_a", 8'h13);
    a_push(8'h21); a_push(8'h22); a_push(8'h23); a_push(8'h24);
    // simultaneous push and pop keeps usage constant
    a_vin = 1'b1; a_din = 8'h25; a_rdy = 1'b1;
    @(negedge clk);
    check("pp_head",  a_dout,  8'h21);
    check("pp_usage", a_usage, 4);
    tick();
    a_vin = 1'b0; a_rdy = 1'b0;
    @(negedge clk);
    check("pp_usage_after", a_usage, 4);
    tick();
    a_pop("wrap_b", 8'h22); a_pop("wrap_b", 8'h23);
    a_pop("wrap_b", 8'h24); a_pop("wrap_b", 8'h25);

    // ---------------- at full, push+pop gives one pop only ----------------
    for (int i = 0; i < 5; i++) a_push(DW'(8'h31 + i));
    a_vin = 1'b1; a_din = 8'h99; a_rdy = 1'b1;
    @(negedge clk);
    check("fullpp_ready", a_rout, 0);
    check("fullpp_head",  a_dout, 8'h31);
    tick();
    a_vin = 1'b0; a_rdy = 1'b0;
    @(negedge clk);
    check("fullpp_usage", a_usage, 4);
    check("fullpp_full",  a_full,  0);
    tick();
    for (int i = 1; i < 5; i++) a_pop("fullpp_drain", DW'(8'h31 + i));
    @(negedge clk);
    check("fullpp_empty", a_empty, 1);
    tick();

    // ---------------- flush with simultaneous push ----------------
    a_push(8'h41); a_push(8'h42); a_push(8'h43);
    a_flush = 1'b1; a_vin = 1'b1; a_din = 8'h77; a_rdy = 1'b1;
    tick();
    a_flush = 1'b0; a_vin = 1'b0; a_rdy = 1'b0;
    @(negedge clk);
    check("flush_usage", a_usage, 0);
    check("flush_empty", a_empty, 1);
    check("flush_peak",  a_peak,  0);
    check("flush_valid", a_vout,  0);
    tick();
    a_push(8'h55);
    @(negedge clk);
    check("postflush_usage", a_usage, 1);
    tick();
    a_pop("postflush_data", 8'h55);

    // ---------------- peak held after fill to 4 and drain ----------------
    for (int i = 0; i < 4; i++) a_push(DW'(8'h61 + i));
    for (int i = 0; i < 4; i++) a_pop("peak_drain", DW'(8'h61 + i));
    @(negedge clk);
    check("peak_usage", a_usage, 0);
    check("peak_held",  a_peak,  PEAK_ON ? 4 : 0);
    tick();

    // ---------------- asynchronous reset mid-fill ----------------
    a_push(8'h71); a_push(8'h72);
    check("midfill_usage", a_usage, 2);
    check("midfill_ae",    a_ae,    0);
    rst_n = 1'b0;
    #1;
    a_reset_state("arst");
    #1 rst_n = 1'b1;
    a_push(8'h81);
    @(negedge clk);
    check("arst_first_data",  a_dout,  8'h81);
    check("arst_first_usage", a_usage, 1);
    tick();
    a_pop("arst_pop", 8'h81);

    // ---------------- fall-through instance ----------------
    b_vin = 1'b1; b_din = 8'hA5; b_rdy = 1'b1;
    @(negedge clk);
    check("ft_data",  b_dout,  8'hA5);
    check("ft_valid", b_vout,  1);
    check("ft_empty", b_empty, 0);
    check("ft_ready", b_rout,  1);
    tick();
    b_vin = 1'b0; b_rdy = 1'b0;
    @(negedge clk);
    check("ft_usage", b_usage, 0);
    check("ft_empty_after", b_empty, 1);
    tick();
    b_vin = 1'b1; b_din = 8'h5A; b_rdy = 1'b0;
    @(negedge clk);
    check("ft_stall_data", b_dout, 8'h5A);
    tick();
    b_vin = 1'b0;
    @(negedge clk);
    check("ft_stall_usage", b_usage, 1);
    check("ft_stall_held",  b_dout,  8'h5A);
    tick();
    b_rdy = 1'b1;
    tick();
    b_rdy = 1'b0;
    @(negedge clk);
    check("ft_final_usage", b_usage, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
